// File: rtl/sensors_scan_acc_pkg.sv
// Shared definitions for the sensor scan accumulator and its downstream divider.
// The result width constant keeps both blocks on the same operand width.
package sensors_scan_acc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam int         RES_W        = 16;
   localparam int         FLT_W        = 8;
   localparam logic [7:0] MAX_TEMP_DEF = 8'd125;

endpackage

// File: rtl/sensors_scan_acc.sv
// Scans the sensor array one sensor per clock and accumulates accepted readings.
// Results are loaded only when a scan completes and held stable for the divider.
module sensors_scan_acc
   import sensors_scan_acc_pkg::*;
#(
   parameter int                NUM_SENSORS = 8,
   parameter int                DATA_W      = 8,
   parameter logic [DATA_W-1:0] MAX_TEMP    = DATA_W'(MAX_TEMP_DEF),
   parameter int                SEL_W       = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic [SEL_W-1:0]  sensor_sel_o,
   input  logic [DATA_W-1:0] sensor_data_i,
   input  logic              sensor_en_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [RES_W-1:0]  temp_sum_o,
   output logic [RES_W-1:0]  nr_active_sensors_o,
   output logic [FLT_W-1:0]  fault_cnt_o,
   output logic              no_sensor_o
);

   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SENSORS - 1);

   state_e             state, state_nxt;
   logic [SEL_W-1:0]   idx;
   logic [RES_W-1:0]   sum_acc, cnt_acc;
   logic [FLT_W-1:0]   flt_acc;
   logic               rd_ok, rd_flt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start_i)         state_nxt = ST_SCAN;
         ST_SCAN: if (idx == LAST_IDX) state_nxt = ST_DONE;
         ST_DONE:                      state_nxt = ST_IDLE;
         default:                      state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o       = 1'b0;
      done_o       = 1'b0;
      sensor_sel_o = '0;
      case (state)
         ST_SCAN: begin
            busy_o       = 1'b1;
            sensor_sel_o = idx;
         end
         ST_DONE: done_o = 1'b1;
         default: ;
      endcase
   end

   // Disabled sensors contribute nothing; enabled out-of-range ones count as faults only.
   assign rd_ok  = sensor_en_i && (sensor_data_i <= MAX_TEMP);
   assign rd_flt = sensor_en_i && (sensor_data_i >  MAX_TEMP);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx                 <= '0;
         sum_acc             <= '0;
         cnt_acc             <= '0;
         flt_acc             <= '0;
         temp_sum_o          <= '0;
         nr_active_sensors_o <= '0;
         fault_cnt_o         <= '0;
         no_sensor_o         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start_i) begin
               idx     <= '0;
               sum_acc <= '0;
               cnt_acc <= '0;
               flt_acc <= '0;
            end
            ST_SCAN: begin
               if (rd_ok) begin
                  sum_acc <= sum_acc + RES_W'(sensor_data_i);
                  cnt_acc <= cnt_acc + 1'b1;
               end
               if (rd_flt && (flt_acc != {FLT_W{1'b1}}))
                  flt_acc <= flt_acc + 1'b1;
               if (idx != LAST_IDX)
                  idx <= idx + 1'b1;
            end
            ST_DONE: begin
               temp_sum_o          <= sum_acc;
               nr_active_sensors_o <= cnt_acc;
               fault_cnt_o         <= flt_acc;
               no_sensor_o         <= (cnt_acc == '0);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sensors_scan_acc.sv
// Directed bench for sensors_scan_acc: sensor readings come from lookup tables
// indexed by the DUT's select output, mimicking the external sensor mux.
module tb_sensors_scan_acc;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [4:0]  sensor_sel_o;
   logic [7:0]  sensor_data_i;
   logic        sensor_en_i;
   logic        busy_o;
   logic        done_o;
   logic [15:0] temp_sum_o;
   logic [15:0] nr_active_sensors_o;
   logic [7:0]  fault_cnt_o;
   logic        no_sensor_o;

   logic [7:0]  rd_tab [32];
   logic        en_tab [32];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign sensor_data_i = rd_tab[sensor_sel_o];
   assign sensor_en_i   = en_tab[sensor_sel_o];

   sensors_scan_acc dut (
      .clk_i               (clk),
      .rst_i               (rst_i),
      .start_i             (start_i),
      .sensor_sel_o        (sensor_sel_o),
      .sensor_data_i       (sensor_data_i),
      .sensor_en_i         (sensor_en_i),
      .busy_o              (busy_o),
      .done_o              (done_o),
      .temp_sum_o          (temp_sum_o),
      .nr_active_sensors_o (nr_active_sensors_o),
      .fault_cnt_o         (fault_cnt_o),
      .no_sensor_o         (no_sensor_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [7:0] base, input logic [7:0] step, input logic en);
      for (int i = 0; i < 32; i++) begin
         rd_tab[i] = base + step * 8'(i);
         en_tab[i] = en;
      end
   endtask

   // Called at a negedge with the DUT idle; start is raised at once.
   task automatic run_scan(input string nm, input int repulse_at,
                           input logic [15:0] e_sum, input logic [15:0] e_cnt,
                           input logic [7:0] e_flt, input logic e_ns);
      int          n;
      logic [15:0] prev_sum;
      logic        seen;
      prev_sum = temp_sum_o;
      start_i  = 1'b1;
      n        = 0;
      seen     = 1'b0;
      while (n < 20 && !seen) begin
         @(negedge clk);
         n++;
         start_i = (n == repulse_at);
         if (done_o) begin
            seen = 1'b1;
            chk({nm, ".done_sel"},  32'(sensor_sel_o), 0);
            chk({nm, ".done_busy"}, 32'(busy_o), 0);
         end else if (n <= 8) begin
            chk({nm, ".sel"},  32'(sensor_sel_o), 32'(n - 1));
            chk({nm, ".busy"}, 32'(busy_o), 1);
            if (n == 4) chk({nm, ".hold"}, 32'(temp_sum_o), 32'(prev_sum));
         end
      end
      start_i = 1'b0;
      chk({nm, ".latency"}, 32'(n), 9);
      @(negedge clk);
      chk({nm, ".done_off"}, 32'(done_o), 0);
      chk({nm, ".idle_busy"}, 32'(busy_o), 0);
      chk({nm, ".sum"},   32'(temp_sum_o), 32'(e_sum));
      chk({nm, ".cnt"},   32'(nr_active_sensors_o), 32'(e_cnt));
      chk({nm, ".flt"},   32'(fault_cnt_o), 32'(e_flt));
      chk({nm, ".nosen"}, 32'(no_sensor_o), 32'(e_ns));
   endtask

   initial begin
      int dcnt;
      rst_i   = 1'b1;
      start_i = 1'b0;
      fill(8'd20, 8'd2, 1'b1);
      repeat (2) @(negedge clk);
      chk("rst.busy",  32'(busy_o), 0);
      chk("rst.done",  32'(done_o), 0);
      chk("rst.sel",   32'(sensor_sel_o), 0);
      chk("rst.sum",   32'(temp_sum_o), 0);
      chk("rst.cnt",   32'(nr_active_sensors_o), 0);
      chk("rst.flt",   32'(fault_cnt_o), 0);
      chk("rst.nosen", 32'(no_sensor_o), 0);
      rst_i = 1'b0;
      @(negedge clk);

      // readings 20,22,..,34 all enabled
      run_scan("basic", 0, 16'd216, 16'd8, 8'd0, 1'b0);

      en_tab[1] = 1'b0; en_tab[3] = 1'b0; en_tab[5] = 1'b0;
      run_scan("disabled", 0, 16'd138, 16'd5, 8'd0, 1'b0);

      fill(8'd25, 8'd0, 1'b1);
      rd_tab[2] = 8'd200; rd_tab[6] = 8'd126;
      run_scan("fault", 0, 16'd150, 16'd6, 8'd2, 1'b0);

      fill(8'd50, 8'd1, 1'b0);
      run_scan("none", 0, 16'd0, 16'd0, 8'd0, 1'b1);

      fill(8'd20, 8'd2, 1'b1);
      run_scan("repulse", 3, 16'd216, 16'd8, 8'd0, 1'b0);
      en_tab[1] = 1'b0; en_tab[3] = 1'b0; en_tab[5] = 1'b0;
      run_scan("b2b", 0, 16'd138, 16'd5, 8'd0, 1'b0);

      // reset in scan cycle 4 must abort without a done pulse
      fill(8'd25, 8'd0, 1'b1);
      rd_tab[2] = 8'd200;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort.busy_pre", 32'(busy_o), 1);
      rst_i = 1'b1;
      #1;
      chk("abort.busy",  32'(busy_o), 0);
      chk("abort.sel",   32'(sensor_sel_o), 0);
      chk("abort.done",  32'(done_o), 0);
      chk("abort.sum",   32'(temp_sum_o), 0);
      chk("abort.cnt",   32'(nr_active_sensors_o), 0);
      chk("abort.flt",   32'(fault_cnt_o), 0);
      chk("abort.nosen", 32'(no_sensor_o), 0);
      @(negedge clk);
      rst_i = 1'b0;
      dcnt  = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done_o) dcnt++;
      end
      chk("abort.no_done", 32'(dcnt), 0);
      chk("abort.sum_after", 32'(temp_sum_o), 0);

      fill(8'd20, 8'd2, 1'b1);
      run_scan("fresh", 0, 16'd216, 16'd8, 8'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sensors_scan_acc.md
Name: sensors_scan_acc

Overview:
- Sequential front-end that scans the temperature sensor array one sensor per clock.
- Accumulates the readings of active, in-range sensors and counts them.
- Presents temp_sum_o (dividend) and nr_active_sensors_o (divisor) to the combinational averaging divider downstream.
- Both results are registered and held stable between scans, so the divider output is stable.

Parameters:
- NUM_SENSORS, 8, number of sensors scanned per pass (2..32).
- DATA_W, 8, width of one sensor reading (unsigned).
- MAX_TEMP, 8'd125, largest legal reading; readings above it are faults.
- SEL_W, 5, width of the sensor select index (must hold NUM_SENSORS-1).

Ports:
- clk_i  in  1  system clock, all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle request to begin a scan.
- sensor_sel_o  out  SEL_W  index of the sensor being sampled; drives the external sensor mux.
- sensor_data_i  in  DATA_W  reading of the selected sensor, combinationally valid in the same cycle as sensor_sel_o.
- sensor_en_i  in  1  selected sensor is present/enabled, same timing as sensor_data_i.
- busy_o  out  1  scan in progress.
- done_o  out  1  one-cycle pulse when new results are loaded.
- temp_sum_o  out  16  sum of accepted readings from the last completed scan.
- nr_active_sensors_o  out  16  count of accepted readings from the last completed scan.
- fault_cnt_o  out  8  enabled sensors with reading > MAX_TEMP in the last scan (saturates at 255).
- no_sensor_o  out  1  last completed scan accepted zero sensors (divisor would be 0).

Behaviour:
- Reset (rst_i=1, asynchronous): FSM to IDLE. All outputs 0, including sensor_sel_o. Internal accumulators 0.
- FSM states IDLE, SCAN, DONE.
- IDLE:
  - sensor_sel_o=0, busy_o=0.
  - On start_i=1: clear the working accumulators (sum, count, faults), set idx=0, go to SCAN.
- SCAN:
  - busy_o=1, sensor_sel_o=idx.
  - Each cycle, sample sensor_data_i and sensor_en_i:
    - en=1 and data<=MAX_TEMP: sum += data (zero-extended to 16 bits), count += 1.
    - en=1 and data>MAX_TEMP: fault += 1 (saturating); sum and count unchanged.
    - en=0: reading ignored.
  - While idx < NUM_SENSORS-1, increment idx. At idx = NUM_SENSORS-1, go to DONE after that sample is accumulated.
- DONE (one cycle):
  - Copy the working accumulators to temp_sum_o, nr_active_sensors_o and fault_cnt_o.
  - no_sensor_o = (count==0).
  - done_o=1, busy_o=0, sensor_sel_o=0. Return to IDLE.
- Latency: the start_i cycle is T. The scan samples sensors in cycles T+1 .. T+NUM_SENSORS. Outputs update at the edge ending cycle T+NUM_SENSORS+1. done_o is high during cycle T+NUM_SENSORS+1.
- Result outputs change only at the DONE load; they hold the previous scan's values during a scan.
- start_i while in SCAN or DONE is ignored; there is no queuing.
- start_i in the cycle immediately after DONE (IDLE) is accepted normally, so back-to-back scans are possible.
- Width rule: 16-bit sum cannot overflow for NUM_SENSORS<=32 and DATA_W=8 (max 32*255 = 8160). No wrap-around handling is required.
- Reset asserted mid-scan aborts the scan immediately and clears all outputs; no done_o pulse is produced.
- When zero sensors are accepted: temp_sum_o=0, nr_active_sensors_o=0, no_sensor_o=1. The downstream divider retains its previous quotient when the divisor is 0.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - MAX_TEMP default;
  - the 16-bit result width constant, so the divider and this block agree on operand width.
- No sub-module is needed; the accumulate/compare datapath and the FSM fit in one module. An optional small saturating counter sensors_fault_sat may be instantiated for fault_cnt.

Test Plan:
- Basic scan, NUM_SENSORS=8, all en=1, readings 20,22,24,26,28,30,32,34, pulse start_i -> after 9 cycles done_o=1, temp_sum_o=216, nr_active_sensors_o=8, fault_cnt_o=0, no_sensor_o=0.
- Sensors 1, 3 and 5 disabled, same readings -> temp_sum_o=20+24+28+32+34=138, nr_active_sensors_o=5.
- Sensor 2 reads 200 (>125), sensor 6 reads 126, others 25 -> fault_cnt_o=2, nr_active_sensors_o=6, temp_sum_o=150.
- All en=0 -> temp_sum_o=0, nr_active_sensors_o=0, no_sensor_o=1, done_o pulses once.
- start_i re-pulsed at cycle 3 of a scan -> ignored, exactly one done_o, results match a single scan. Then start_i on the cycle after DONE -> second scan runs, sensor_sel_o sequences 0..7 again.
- rst_i asserted at scan cycle 4 -> all outputs 0 asynchronously, no done_o. A new start after reset produces correct fresh results, not merged with the partial scan.
